// File: rtl/mycpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mycpu_pkg
// Brief    : Shared CPU types: FU function select, multiplier FSM states and
//            the multiplier saturation value.
// Revision : 1.0 - initial release
// ============================================================================
package mycpu_pkg;

  localparam int MUL_W = 16;

  typedef enum logic [3:0] {
    FCLR = 4'h0,
    FADD = 4'h1,
    FSUB = 4'h2,
    FAND = 4'h3,
    FOR  = 4'h4,
    FXOR = 4'h5,
    FSHL = 4'h6,
    FSHR = 4'h7
  } fs_t;

  typedef enum logic [2:0] {
    MUL_IDLE = 3'd0,
    MUL_ADD  = 3'd1,
    MUL_SHL  = 3'd2,
    MUL_SHR  = 3'd3,
    MUL_DONE = 3'd4
  } mul_state_t;

  localparam logic [MUL_W-1:0] MUL_SAT_VAL = 16'h7FFF;

endpackage
`default_nettype wire

// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq
// Brief    : Sequential 16x16 unsigned shift-and-add multiplier driving a
//            shared external FU. Define MUL_SAT_EN to saturate on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module mul_seq
  import mycpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MUL_W-1:0] a_in,
  input  logic [MUL_W-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [MUL_W-1:0] product,
  output logic             ovf,
  output logic [MUL_W-1:0] fu_a,
  output logic [MUL_W-1:0] fu_b,
  output logic [3:0]       fu_fs,
  input  logic [MUL_W-1:0] fu_f,
  input  logic             fu_z
);

  mul_state_t       state_q, state_d;
  logic [MUL_W-1:0] acc_q, acc_d;
  logic [MUL_W-1:0] mcand_q, mcand_d;
  logic [MUL_W-1:0] mplier_q, mplier_d;
  logic             lost_q, lost_d;
  logic             carry_q, carry_d;
  logic [MUL_W-1:0] product_q, product_d;
  logic             ovf_q, ovf_d;

  fs_t              fs_w;
  logic [MUL_W-1:0] result_w;

`ifdef MUL_SAT_EN
  assign result_w = carry_q ? MUL_SAT_VAL : acc_q;
`else
  assign result_w = acc_q;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    lost_d    = lost_q;
    carry_d   = carry_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    fs_w      = FCLR;
    fu_a      = '0;
    fu_b      = '0;

    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          mcand_d  = a_in;
          mplier_d = b_in;
          acc_d    = '0;
          lost_d   = 1'b0;
          carry_d  = 1'b0;
          if (b_in == '0)
            state_d = MUL_DONE;
          else if (b_in[0])
            state_d = MUL_ADD;
          else
            state_d = MUL_SHL;
        end
      end

      // A wrapped sum, or adding a multiplicand that already shifted a 1 out
      // of the top, both mean the true product no longer fits in 16 bits.
      MUL_ADD: begin
        fs_w    = FADD;
        fu_a    = acc_q;
        fu_b    = mcand_q;
        acc_d   = fu_f;
        carry_d = carry_q | (fu_f < acc_q) | lost_q;
        state_d = MUL_SHL;
      end

      MUL_SHL: begin
        fs_w    = FSHL;
        fu_b    = mcand_q;
        mcand_d = fu_f;
        if (mcand_q[MUL_W-1])
          lost_d = 1'b1;
        state_d = MUL_SHR;
      end

      MUL_SHR: begin
        fs_w     = FSHR;
        fu_b     = mplier_q;
        mplier_d = fu_f;
        if (fu_z)
          state_d = MUL_DONE;
        else if (fu_f[0])
          state_d = MUL_ADD;
        else
          state_d = MUL_SHL;
      end

      MUL_DONE: begin
        product_d = result_w;
        ovf_d     = carry_q;
        state_d   = MUL_IDLE;
      end

      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MUL_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      lost_q    <= 1'b0;
      carry_q   <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      lost_q    <= lost_d;
      carry_q   <= carry_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  // The result is already visible during the DONE pulse, then held.
  assign busy    = (state_q != MUL_IDLE);
  assign done    = (state_q == MUL_DONE);
  assign product = done ? result_w : product_q;
  assign ovf     = done ? carry_q  : ovf_q;
  assign fu_fs   = fs_w;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_seq
// Brief    : Directed bench for mul_seq with a behavioural FU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_seq;
  import mycpu_pkg::*;

  localparam int BUDGET = 100;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a_in, b_in;
  logic        busy, done, ovf;
  logic [15:0] product;
  logic [15:0] fu_a, fu_b, fu_f;
  logic [3:0]  fu_fs;
  logic        fu_z;

  int checks = 0;
  int errors = 0;

  mul_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf),
    .fu_a    (fu_a),
    .fu_b    (fu_b),
    .fu_fs   (fu_fs),
    .fu_f    (fu_f),
    .fu_z    (fu_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    fu_f = 16'h0000;
    case (fu_fs)
      FADD:    fu_f = fu_a + fu_b;
      FSHL:    fu_f = {fu_b[14:0], 1'b0};
      FSHR:    fu_f = {1'b0, fu_b[15:1]};
      default: fu_f = 16'h0000;
    endcase
  end
  assign fu_z = (fu_f == 16'h0000);

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p_wrap;
    logic [15:0] p_sat;
    logic        ovf;
    int          lat;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one multiply from IDLE (called just after a negedge) and check
  // latency, result, flag, FADD count and the hold after the done pulse.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_p, input logic exp_o,
                         input int exp_lat, input int poke, input string nm);
    int n;
    int adds;
    bit got;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = 16'hDEAD;
    b_in  = 16'hBEEF;
    n     = 0;
    adds  = 0;
    got   = 1'b0;
    while (!got && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (n == poke) begin
        start = 1'b1;
        a_in  = 16'h0007;
        b_in  = 16'h0007;
      end else begin
        start = 1'b0;
      end
      if (fu_fs == FADD) adds++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      chk({nm, " timeout"}, 32'(n), 32'(exp_lat));
    end else begin
      chk({nm, " latency"}, 32'(n), 32'(exp_lat));
      chk({nm, " product"}, 32'(product), 32'(exp_p));
      chk({nm, " ovf"}, 32'(ovf), 32'(exp_o));
      chk({nm, " fadd_count"}, 32'(adds), 32'($countones(b)));
      @(negedge clk);
      chk({nm, " done_pulse"}, 32'(done), 32'd0);
      chk({nm, " idle"}, 32'(busy), 32'd0);
      chk({nm, " held_product"}, 32'(product), 32'(exp_p));
      chk({nm, " held_ovf"}, 32'(ovf), 32'(exp_o));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    int n;
    logic [15:0] ep;

    vecs[0] = '{16'h0003, 16'h0005, 16'h000F, 16'h000F, 1'b0,  9};
    vecs[1] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0,  1};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0,  4};
    vecs[3] = '{16'hFFFF, 16'h0002, 16'hFFFE, 16'h7FFF, 1'b1,  6};
    vecs[4] = '{16'h0100, 16'h0100, 16'h0000, 16'h7FFF, 1'b1, 20};
    vecs[5] = '{16'h0002, 16'h0003, 16'h0006, 16'h0006, 1'b0,  7};
    vecs[6] = '{16'h00FF, 16'h0101, 16'hFFFF, 16'hFFFF, 1'b0, 21};
    vecs[7] = '{16'h1234, 16'h0010, 16'h2340, 16'h7FFF, 1'b1, 12};
    vecs[8] = '{16'hC000, 16'h0003, 16'h4000, 16'h7FFF, 1'b1,  7};
    vecs[9] = '{16'h6000, 16'h0003, 16'h2000, 16'h7FFF, 1'b1,  7};

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = 16'h0;
    b_in  = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset product", 32'(product), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset fu_fs", 32'(fu_fs), 32'(FCLR));
    chk("reset fu_b", 32'(fu_b), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
`ifdef MUL_SAT_EN
      ep = vecs[i].p_sat;
`else
      ep = vecs[i].p_wrap;
`endif
      run_mul(vecs[i].a, vecs[i].b, ep, vecs[i].ovf, vecs[i].lat, 0,
              $sformatf("vec%0d", i));
    end

    // start pulsed mid-operation must be ignored entirely
    run_mul(16'h0003, 16'h0005, 16'h000F, 1'b0, 9, 3, "poke");
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("poke extra_done", 32'(dcount), 32'd0);

    // start held high: ignored in DONE, accepted in the following IDLE cycle
    start = 1'b1;
    a_in  = 16'h0002;
    b_in  = 16'h0003;
    @(posedge clk);
    repeat (7) @(negedge clk);
    chk("held done", 32'(done), 32'd1);
    chk("held product", 32'(product), 32'h6);
    @(negedge clk);
    chk("held idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("held reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    n = 0;
    while (busy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("held drain", 32'(busy), 32'd0);

    // asynchronous reset during SHL of 7x7
    start = 1'b1;
    a_in  = 16'h0007;
    b_in  = 16'h0007;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst in_shl", 32'(fu_fs), 32'(FSHL));
    rst_n = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst product", 32'(product), 32'd0);
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("rst no_done", 32'(dcount), 32'd0);
    run_mul(16'h0002, 16'h0003, 16'h0006, 1'b0, 7, 0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
